// File: rtl/wt_cache_pkg.sv
// wt_cache_pkg: shared write-through L1 data cache geometry and flush sequencer state encoding
package wt_cache_pkg;

    localparam int unsigned DCACHE_NUM_SETS     = 4;
    localparam int unsigned DCACHE_CL_IDX_WIDTH = $clog2(DCACHE_NUM_SETS);
    localparam int unsigned DCACHE_SET_ASSOC    = 4;

    typedef logic [2:0] flush_state_e;

    localparam flush_state_e FS_INIT  = 3'd0;
    localparam flush_state_e FS_IDLE  = 3'd1;
    localparam flush_state_e FS_DRAIN = 3'd2;
    localparam flush_state_e FS_INV   = 3'd3;
    localparam flush_state_e FS_ACK   = 3'd4;

endpackage

// File: rtl/wt_dcache_flush_seq.sv
// wt_dcache_flush_seq: whole-cache invalidation sequencer for the write-through L1 data cache
//   clk_i, rst_ni                      clock, async active-low reset
//   enable_i, flush_i                  CSR cache enable, held flush request
//   wbuffer_empty_i, miss_busy_i       drain status of write buffer and miss unit
//   wr_cl_gnt_i                        cacheline write port grant
//   flush_ack_o                        one-cycle flush completion
//   cache_en_o, stall_o, busy_o        effective enable, request stall, not-idle
//   wr_cl_vld_o/idx_o/we_o, wr_vld_bits_o  invalidation write to the tag/valid memory
module wt_dcache_flush_seq
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumSets  = DCACHE_NUM_SETS,
    parameter int unsigned SetAssoc = DCACHE_SET_ASSOC,
    parameter int unsigned IdxWidth = $clog2(NumSets)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic                flush_i,
    input  logic                wbuffer_empty_i,
    input  logic                miss_busy_i,
    input  logic                wr_cl_gnt_i,
    output logic                flush_ack_o,
    output logic                cache_en_o,
    output logic                stall_o,
    output logic                busy_o,
    output logic                wr_cl_vld_o,
    output logic [IdxWidth-1:0] wr_cl_idx_o,
    output logic [SetAssoc-1:0] wr_cl_we_o,
    output logic [SetAssoc-1:0] wr_vld_bits_o
);

    flush_state_e        state_q, state_d;
    logic [IdxWidth-1:0] idx_q, idx_d;
    logic                cache_en_q, cache_en_d;
    logic                ext_q, ext_d;
    logic                skip_q, skip_d;
    logic                walk, last;

    assign walk = (state_q == FS_INIT) || (state_q == FS_INV);
    assign last = idx_q == IdxWidth'(NumSets - 1);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cache_en_d = cache_en_q;
        ext_d      = ext_q;
        skip_d     = 1'b0;
        case (state_q)
            FS_INIT, FS_INV: begin
                if (wr_cl_gnt_i) begin
                    idx_d = last ? '0 : idx_q + 1'b1;
                    if (last) state_d = (state_q == FS_INV && ext_q) ? FS_ACK : FS_IDLE;
                end
            end
            FS_IDLE: begin
                cache_en_d = enable_i;
                // skip_q masks a flush_i still held over from the request just acked
                if ((flush_i && !skip_q) || (cache_en_q && !enable_i)) begin
                    state_d = FS_DRAIN;
                    ext_d   = flush_i && !skip_q;
                end
            end
            FS_DRAIN: state_d = (wbuffer_empty_i && !miss_busy_i) ? FS_INV : FS_DRAIN;
            FS_ACK: begin
                cache_en_d = enable_i;
                skip_d     = 1'b1;
                state_d    = FS_IDLE;
            end
            default: state_d = FS_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= FS_INIT;
            idx_q      <= '0;
            cache_en_q <= 1'b0;
            ext_q      <= 1'b0;
            skip_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cache_en_q <= cache_en_d;
            ext_q      <= ext_d;
            skip_q     <= skip_d;
        end
    end

    assign busy_o        = state_q != FS_IDLE;
    assign stall_o       = busy_o;
    assign cache_en_o    = !busy_o && cache_en_q;
    assign flush_ack_o   = state_q == FS_ACK;
    assign wr_cl_vld_o   = walk;
    assign wr_cl_idx_o   = walk ? idx_q : '0;
    assign wr_cl_we_o    = {SetAssoc{walk}};
    assign wr_vld_bits_o = '0;

    a_ack_drained: assert property (@(posedge clk_i) disable iff (!rst_ni)
        flush_ack_o |-> wbuffer_empty_i);
    a_wr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        wr_cl_vld_o && !wr_cl_gnt_i |=> wr_cl_vld_o && $stable(wr_cl_idx_o));
    a_flush_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == FS_DRAIN || state_q == FS_INV) && ext_q |-> flush_i);

endmodule

// File: tb/tb_wt_dcache_flush_seq.sv
// tb_wt_dcache_flush_seq: vector table, corner sequences and random run against a flag-based reference model
module tb_wt_dcache_flush_seq;
    import wt_cache_pkg::*;

    localparam int N = DCACHE_NUM_SETS;
    localparam int W = DCACHE_CL_IDX_WIDTH;
    localparam int A = DCACHE_SET_ASSOC;

    logic         clk_i, rst_ni, enable_i, flush_i, wbuffer_empty_i, miss_busy_i, wr_cl_gnt_i;
    logic         flush_ack_o, cache_en_o, stall_o, busy_o, wr_cl_vld_o;
    logic [W-1:0] wr_cl_idx_o;
    logic [A-1:0] wr_cl_we_o, wr_vld_bits_o;

    wt_dcache_flush_seq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .flush_i(flush_i),
        .wbuffer_empty_i(wbuffer_empty_i), .miss_busy_i(miss_busy_i), .wr_cl_gnt_i(wr_cl_gnt_i),
        .flush_ack_o(flush_ack_o), .cache_en_o(cache_en_o), .stall_o(stall_o), .busy_o(busy_o),
        .wr_cl_vld_o(wr_cl_vld_o), .wr_cl_idx_o(wr_cl_idx_o), .wr_cl_we_o(wr_cl_we_o),
        .wr_vld_bits_o(wr_vld_bits_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a walk is "write positions 0..N-1, one per grant";
    // an external walk ends in one ack cycle, the reset walk and internal walks do not.
    bit m_walk, m_drain, m_ack, m_ext, m_en, m_skip;
    int m_pos;

    task automatic m_reset();
        m_walk = 1; m_drain = 0; m_ack = 0; m_ext = 0; m_en = 0; m_skip = 0; m_pos = 0;
    endtask

    function automatic bit m_idle();
        return !m_walk && !m_drain && !m_ack;
    endfunction

    task automatic m_step();
        if (m_walk) begin
            if (wr_cl_gnt_i) begin
                m_pos++;
                if (m_pos == N) begin
                    m_walk = 0; m_pos = 0; m_ack = m_ext; m_ext = 0;
                end
            end
        end else if (m_drain) begin
            if (wbuffer_empty_i && !miss_busy_i) begin
                m_drain = 0; m_walk = 1;
            end
        end else if (m_ack) begin
            m_ack = 0; m_en = enable_i; m_skip = 1;
        end else begin
            if ((flush_i && !m_skip) || (m_en && !enable_i)) begin
                m_drain = 1; m_ext = flush_i && !m_skip;
            end
            m_en = enable_i; m_skip = 0;
        end
    endtask

    task automatic cmp_model();
        chk("m_ack",   32'(flush_ack_o),   32'(m_ack));
        chk("m_en",    32'(cache_en_o),    32'(m_idle() && m_en));
        chk("m_stall", 32'(stall_o),       32'(!m_idle()));
        chk("m_busy",  32'(busy_o),        32'(!m_idle()));
        chk("m_vld",   32'(wr_cl_vld_o),   32'(m_walk));
        chk("m_idx",   32'(wr_cl_idx_o),   m_walk ? m_pos : 0);
        chk("m_we",    32'(wr_cl_we_o),    m_walk ? (1 << A) - 1 : 0);
        chk("m_bits",  32'(wr_vld_bits_o), 0);
    endtask

    // Inputs are set by the caller before the edge; outputs are compared 1ns after the next negedge.
    task automatic tick();
        m_step();
        @(negedge clk_i);
        #1 cmp_model();
    endtask

    task automatic settle();
        flush_i = 0; wbuffer_empty_i = 1; miss_busy_i = 0; wr_cl_gnt_i = 1;
        tick(); tick();
    endtask

    typedef struct packed {
        logic fl, en, emp, gnt;
        logic ack, cen, stl, vld;
        logic [7:0] idx;
    } vec_t;

    vec_t tbl[14];
    int   rise, ackrow, acks, cnt, pidx;

    initial begin
        for (int i = 0; i < 4; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'(i)};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0};
        for (int i = 0; i < 4; i++) tbl[7+i] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'(i)};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};

        rst_ni = 0; enable_i = 1; flush_i = 0; wbuffer_empty_i = 1; miss_busy_i = 0; wr_cl_gnt_i = 1;
        m_reset();
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst_ack",   32'(flush_ack_o), 0);
        chk("rst_en",    32'(cache_en_o),  0);
        chk("rst_stall", 32'(stall_o),     1);
        chk("rst_busy",  32'(busy_o),      1);
        chk("rst_vld",   32'(wr_cl_vld_o), 1);
        chk("rst_idx",   32'(wr_cl_idx_o), 0);
        rst_ni = 1;

        // init walk, then one external flush with a drained cache
        rise = -1; ackrow = -1; acks = 0;
        for (int i = 0; i < 14; i++) begin
            flush_i = tbl[i].fl; enable_i = tbl[i].en; wbuffer_empty_i = tbl[i].emp; wr_cl_gnt_i = tbl[i].gnt;
            chk("t_ack",   32'(flush_ack_o), 32'(tbl[i].ack));
            chk("t_en",    32'(cache_en_o),  32'(tbl[i].cen));
            chk("t_stall", 32'(stall_o),     32'(tbl[i].stl));
            chk("t_busy",  32'(busy_o),      32'(tbl[i].stl));
            chk("t_vld",   32'(wr_cl_vld_o), 32'(tbl[i].vld));
            chk("t_idx",   32'(wr_cl_idx_o), 32'(tbl[i].idx));
            if (tbl[i].fl && rise < 0) rise = i;
            if (flush_ack_o && ackrow < 0) ackrow = i;
            if (flush_ack_o) acks++;
            tick();
        end
        chk("ack_latency", ackrow - rise + 1, N + 3);
        chk("ack_count", acks, 1);

        // write buffer stays busy for 10 cycles
        settle();
        flush_i = 1; wbuffer_empty_i = 0;
        tick();
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (wr_cl_vld_o) cnt++;
            tick();
        end
        chk("drain_vld", cnt, 0);
        wbuffer_empty_i = 1;
        chk("drain_last_vld", 32'(wr_cl_vld_o), 0);
        tick();
        chk("walk_start_vld", 32'(wr_cl_vld_o), 1);
        chk("walk_start_idx", 32'(wr_cl_idx_o), 0);
        for (int k = 0; k < 20 && !flush_ack_o; k++) tick();
        chk("drain_ack", 32'(flush_ack_o), 1);
        flush_i = 0;
        tick();

        // grant alternates 0,1,0,1 during the walk
        settle();
        flush_i = 1;
        tick(); tick();
        cnt = 0;
        for (int k = 0; k < 40 && wr_cl_vld_o; k++) begin
            wr_cl_gnt_i = k[0];
            pidx = int'(wr_cl_idx_o);
            cnt++;
            tick();
            if (!wr_cl_gnt_i && wr_cl_vld_o) chk("gnt_hold_idx", 32'(wr_cl_idx_o), pidx);
        end
        chk("gnt_walk_len", cnt, 2 * N);
        chk("gnt_ack", 32'(flush_ack_o), 1);
        flush_i = 0;
        tick();

        // CSR disable starts an internal flush
        settle();
        chk("int_en_before", 32'(cache_en_o), 1);
        enable_i = 0;
        tick();
        cnt = 0; acks = 0;
        for (int k = 0; k < 30 && busy_o; k++) begin
            if (wr_cl_vld_o) cnt++;
            if (flush_ack_o) acks++;
            chk("int_stall", 32'(stall_o), 1);
            tick();
        end
        chk("int_walk", cnt, N);
        chk("int_ack", acks, 0);
        chk("int_busy", 32'(busy_o), 0);
        chk("int_en_after", 32'(cache_en_o), 0);
        enable_i = 1;
        tick(); tick();

        // reset at index 2 of a flush walk
        flush_i = 1;
        tick(); tick(); tick(); tick();
        chk("pre_rst_idx", 32'(wr_cl_idx_o), 2);
        flush_i = 0; rst_ni = 0;
        m_reset();
        #2;
        chk("mid_rst_vld", 32'(wr_cl_vld_o), 1);
        chk("mid_rst_idx", 32'(wr_cl_idx_o), 0);
        chk("mid_rst_busy", 32'(busy_o), 1);
        chk("mid_rst_ack", 32'(flush_ack_o), 0);
        rst_ni = 1;
        acks = 0;
        for (int k = 0; k < N; k++) begin
            chk("reinit_idx", 32'(wr_cl_idx_o), k);
            if (flush_ack_o) acks++;
            tick();
        end
        chk("reinit_ack", acks, 0);
        chk("reinit_idle", 32'(busy_o), 0);

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            flush_i = flush_i ? (m_ack ? 1'($urandom_range(0, 1)) : 1'b1) : ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 29) == 0) enable_i = !enable_i;
            miss_busy_i = $urandom_range(0, 3) == 0;
            wbuffer_empty_i = (m_ack || m_walk) ? 1'b1 : ($urandom_range(0, 2) != 0);
            wr_cl_gnt_i = $urandom_range(0, 2) != 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
